down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter and load-value width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load, input, 1 bit: loads load_val into Q and the reload register.
REQ-005 SHALL have port load_val, input, WIDTH bits: start/reload count value.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port periodic, input, 1 bit: 1 selects auto-reload at terminal count; 0 selects one-shot.
REQ-008 SHALL have port Q, output, WIDTH bits: current count.
REQ-009 SHALL have port tc, output, 1 bit: registered terminal-count pulse.
REQ-010 SHALL have port busy, output, 1 bit: high while the FSM is in RUN.

Function
REQ-011 SHALL implement a three-state FSM: IDLE (never loaded), RUN (counting), DONE (one-shot expired or zero loaded).
REQ-012 SHALL give load priority over en in every state: Q <= load_val and reload_reg <= load_val on the same edge.
REQ-013 SHALL, on load with load_val != 0, enter RUN; with load_val == 0, enter DONE with tc = 0.
REQ-014 SHALL, in RUN with en = 1 and Q > 1, decrement Q by exactly 1 per edge, with tc = 0.
REQ-015 SHALL, in RUN with en = 1 and Q == 1, set Q <= 0 and assert tc for exactly the following cycle.
REQ-016 SHALL sample periodic on the Q == 1 decrement edge: if 1, stay in RUN; if 0, enter DONE.
REQ-017 SHALL, in RUN with Q == 0 and en = 1 (periodic reload pending), set Q <= reload_reg with no tc.
REQ-018 SHALL, with en = 0 and load = 0, hold Q and the state, and deassert tc.
REQ-019 SHALL, in IDLE or DONE, hold Q and ignore en until the next load.
REQ-020 SHALL, on load during RUN, restart from the new load_val and suppress any tc that would have fired on that edge.
REQ-021 SHALL perform all arithmetic modulo 2^WIDTH, with no underflow below 0 in any state.
REQ-022 SHALL drive busy = 1 only in RUN, decoded from the state register.
REQ-023 SHALL drive tc from a register, never combinationally from Q.

Reset
REQ-024 SHALL, on reset low, asynchronously force Q = 0, reload_reg = 0, tc = 0, busy = 0 and state IDLE, independent of clk.
REQ-025 SHALL, on reset deassertion, act on inputs from the first rising clk edge thereafter; reset asserted mid-count SHALL discard the count and the pending tc.

Structure
REQ-026 SHALL take its FSM state encodings (IDLE, RUN, DONE) as localparam constants from a shared package, counters_pkg.
REQ-027 SHALL contain one natural sub-module, dc_reg: a WIDTH-bit register with async active-low clear and a load enable, used for Q and reload_reg.
REQ-028 SHALL contain no other sub-modules; the FSM and next-count logic SHALL reside in down_counter.

Verification
REQ-029 SHALL verify reset: reset low mid-count at Q = 5 -> Q = 0, tc = 0, busy = 0 immediately, without a clock edge.
REQ-030 SHALL verify one-shot: load 3, periodic = 0, en = 1 -> Q = 3, 2, 1, 0; tc high for exactly one cycle at Q = 0; busy falls; Q stays 0 under continued en.
REQ-031 SHALL verify periodic: load 2, periodic = 1, en = 1 -> Q = 2, 1, 0, 2, 1, 0; tc high once per 0 reached.
REQ-032 SHALL verify en gating: load 4, en pattern 1, 0, 0, 1 -> Q = 4, 3, 3, 3, 2; tc never asserted.
REQ-033 SHALL verify load priority: load 9 with en = 1 at Q = 1 -> Q = 9, tc = 0, state RUN.
REQ-034 SHALL verify zero load and width: load 0 -> DONE, busy = 0, tc = 0; WIDTH = 4, load 15 -> 15 decrements to 0, no wrap to 15 in one-shot mode.

Source files
------------

// File: rtl/counters_pkg.sv
// counters_pkg: shared definitions for the counter family.
// Holds the down_counter FSM state encodings.
package counters_pkg;

  localparam logic [1:0] IDLE_ENC = 2'b00;
  localparam logic [1:0] RUN_ENC  = 2'b01;
  localparam logic [1:0] DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,  // never loaded since reset
    RUN  = RUN_ENC,   // counting
    DONE = DONE_ENC   // one-shot expired, or zero was loaded
  } dc_state_t;

endpackage

// File: rtl/down_counter_dc_reg.sv
// dc_reg: WIDTH-bit register with asynchronous active-low clear and load enable.
//   clk   - clock, rising edge
//   reset - asynchronous clear, active low
//   en    - load enable; q takes d on the rising edge when high
//   d     - data in
//   q     - registered data out
module dc_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/down_counter.sv
// down_counter: loadable down counter with one-shot or periodic auto-reload.
//   clk      - clock, rising edge
//   reset    - asynchronous reset, active low
//   load     - load load_val into Q and the reload register (beats en)
//   load_val - start / reload value
//   en       - count enable
//   periodic - 1: reload at terminal count, 0: one-shot
//   Q        - current count
//   tc       - registered terminal-count pulse, high the cycle Q reaches 0
//   busy     - high while counting (RUN)
module down_counter
  import counters_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             periodic,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy
);

  dc_state_t        state;
  dc_state_t        state_nxt;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] q_nxt;
  logic             q_we;
  logic             rl_we;
  logic             tc_nxt;

  // State register, with the tc pulse registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      tc    <= tc_nxt;
    end
  end

  // Next state and next count.
  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    q_we      = 1'b0;
    rl_we     = 1'b0;
    tc_nxt    = 1'b0;
    if (load) begin
      q_nxt     = load_val;
      q_we      = 1'b1;
      rl_we     = 1'b1;
      state_nxt = (load_val == '0) ? DONE : RUN;
    end else if (state == RUN && en) begin
      if (Q == WIDTH'(1)) begin
        q_nxt     = '0;
        q_we      = 1'b1;
        tc_nxt    = 1'b1;
        state_nxt = periodic ? RUN : DONE;
      end else if (Q == '0) begin
        // Only reachable in RUN after a periodic terminal count.
        q_nxt = reload_q;
        q_we  = 1'b1;
      end else begin
        q_nxt = Q - WIDTH'(1);
        q_we  = 1'b1;
      end
    end
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state == RUN);
  end

  dc_reg #(.WIDTH(WIDTH)) u_count (
    .clk   (clk),
    .reset (reset),
    .en    (q_we),
    .d     (q_nxt),
    .q     (Q)
  );

  dc_reg #(.WIDTH(WIDTH)) u_reload (
    .clk   (clk),
    .reset (reset),
    .en    (rl_we),
    .d     (load_val),
    .q     (reload_q)
  );

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed self-checking bench for down_counter (WIDTH = 4).
module tb_down_counter;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       periodic;
  logic [3:0] Q;
  logic       tc;
  logic       busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];

  down_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .periodic (periodic),
    .Q        (Q),
    .tc       (tc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard: got empty queue want entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".Q"},    Q,            e.q);
      check({e.tag, ".tc"},   {3'b0, tc},   {3'b0, e.tc});
      check({e.tag, ".busy"}, {3'b0, busy}, {3'b0, e.busy});
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, clock, compare.
  task automatic step(input logic ld, input logic [3:0] lv, input logic e, input logic per,
                      input logic [3:0] eq, input logic etc, input logic ebusy, input string tag);
    exp_t x;
    load = ld; load_val = lv; en = e; periodic = per;
    x.q = eq; x.tc = etc; x.busy = ebusy; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic expect_now(input logic [3:0] eq, input logic etc, input logic ebusy, input string tag);
    exp_t x;
    x.q = eq; x.tc = etc; x.busy = ebusy; x.tag = tag;
    sb.push_back(x);
    pop_check();
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; periodic = 1'b0;
    #3;
    expect_now(4'd0, 1'b0, 1'b0, "rst_init");
    @(negedge clk);
    reset = 1'b1;

    // IDLE ignores en
    step(0, 0, 1, 0, 4'd0, 0, 0, "idle_en");

    // one-shot from 3
    step(1, 3, 0, 0, 4'd3, 0, 1, "os_load");
    step(0, 0, 1, 0, 4'd2, 0, 1, "os_2");
    step(0, 0, 1, 0, 4'd1, 0, 1, "os_1");
    step(0, 0, 1, 0, 4'd0, 1, 0, "os_0");
    step(0, 0, 1, 0, 4'd0, 0, 0, "os_hold_a");
    step(0, 0, 1, 0, 4'd0, 0, 0, "os_hold_b");

    // periodic from 2
    step(1, 2, 0, 1, 4'd2, 0, 1, "per_load");
    step(0, 0, 1, 1, 4'd1, 0, 1, "per_1a");
    step(0, 0, 1, 1, 4'd0, 1, 1, "per_0a");
    step(0, 0, 1, 1, 4'd2, 0, 1, "per_2b");
    step(0, 0, 1, 1, 4'd1, 0, 1, "per_1b");
    step(0, 0, 1, 1, 4'd0, 1, 1, "per_0b");
    step(0, 0, 1, 1, 4'd2, 0, 1, "per_2c");

    // en gating from 4
    step(1, 4, 0, 0, 4'd4, 0, 1, "gate_load");
    step(0, 0, 1, 0, 4'd3, 0, 1, "gate_en1");
    step(0, 0, 0, 0, 4'd3, 0, 1, "gate_en0a");
    step(0, 0, 0, 0, 4'd3, 0, 1, "gate_en0b");
    step(0, 0, 1, 0, 4'd2, 0, 1, "gate_en1b");

    // load beats en at Q == 1, tc suppressed
    step(0, 0, 1, 0, 4'd1, 0, 1, "prio_q1");
    step(1, 9, 1, 0, 4'd9, 0, 1, "prio_load");
    step(0, 0, 1, 0, 4'd8, 0, 1, "prio_after");

    // zero load goes straight to DONE
    step(1, 0, 1, 0, 4'd0, 0, 0, "zero_load");
    step(0, 0, 1, 1, 4'd0, 0, 0, "zero_hold");

    // full-width one-shot, no wrap
    step(1, 15, 0, 0, 4'd15, 0, 1, "w15_load");
    for (int i = 14; i >= 0; i--)
      step(0, 0, 1, 0, i[3:0], (i == 0), (i != 0), "w15_cnt");
    step(0, 0, 1, 0, 4'd0, 0, 0, "w15_nowrap");

    // async reset mid-count at Q = 5, with a pending tc discarded
    step(1, 7, 0, 0, 4'd7, 0, 1, "rst_load");
    step(0, 0, 1, 0, 4'd6, 0, 1, "rst_6");
    step(0, 0, 1, 0, 4'd5, 0, 1, "rst_5");
    #2;
    reset = 1'b0;
    #1;
    expect_now(4'd0, 1'b0, 1'b0, "rst_async");
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 1, 0, 4'd0, 0, 0, "rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
